// File: rtl/uart_tx_serializer_if.sv
// FIFO read-side bundle between the transmit FIFO and the UART serializer.
// The serializer owns the master side (issues pops, consumes flag and data).
interface uart_tx_serializer_if #(
   parameter int DATA_BITS = 8
);
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_data;
   logic                 fifo_pop;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_pop
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_pop
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART tx serializer: pops one FIFO entry per frame, sends start/data LSB-first/[even parity]/stop.
// Latency: pop 1 cycle after an enabled non-empty IDLE cycle, start bit 3 cycles after it.
// Backpressure: pops only from IDLE with tx_enable high; parity bit compiled in with UART_TX_PARITY_EN.
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 tx_enable,
   uart_tx_serializer_if.master fifo_if,
   output logic                 tx,
   output logic                 busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_WAIT,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
   logic                 par;
`endif

   // Outputs are registered with the value belonging to the state being entered.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state            <= S_IDLE;
         cnt              <= '0;
         bit_idx          <= '0;
         shreg            <= '0;
         tx               <= 1'b1;
         busy             <= 1'b0;
         fifo_if.fifo_pop <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par              <= 1'b0;
`endif
      end else begin
         fifo_if.fifo_pop <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tx_enable && !fifo_if.fifo_empty) begin
                  state            <= S_POP;
                  fifo_if.fifo_pop <= 1'b1;
                  busy             <= 1'b1;
               end
            end
            S_POP: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               shreg   <= fifo_if.fifo_data;
`ifdef UART_TX_PARITY_EN
               par     <= ^fifo_if.fifo_data;
`endif
               cnt     <= '0;
               bit_idx <= '0;
               tx      <= 1'b0;
               state   <= S_START;
            end
            S_START: begin
               if (cnt == CNT_MAX) begin
                  cnt   <= '0;
                  tx    <= shreg[0];
                  state <= S_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == CNT_MAX) begin
                  cnt   <= '0;
                  shreg <= shreg >> 1;
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     tx      <= par;
                     state   <= S_PARITY;
`else
                     tx      <= 1'b1;
                     state   <= S_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (cnt == CNT_MAX) begin
                  cnt   <= '0;
                  tx    <= 1'b1;
                  state <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (cnt == CNT_MAX) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: FIFO model drives the slave side, frames checked
// against bit lists built from the byte value (start, LSB-first data, even parity, stop).
module tb_uart_tx_serializer;
   localparam int CPB = 4;
   localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NBITS  = DB + 2 + PB;
   localparam int N_RAND = 6;

   logic clock;
   logic resetn;
   logic tx_enable;
   logic tx;
   logic busy;

   uart_tx_serializer_if #(.DATA_BITS(DB)) fifo_if ();

   uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .tx_enable (tx_enable),
      .fifo_if   (fifo_if),
      .tx        (tx),
      .busy      (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int pop_cnt = 0;
   int pop_consec = 0;
   int exp_pops = 0;
   bit prev_pop = 1'b0;
   logic [DB-1:0] fifo_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample on the falling edge and let the FIFO model react to a pop.
   task automatic step();
      @(negedge clock);
      if (fifo_if.fifo_pop === 1'b1) begin
         pop_cnt++;
         if (prev_pop) pop_consec++;
         if (fifo_q.size() > 0) fifo_if.fifo_data = fifo_q.pop_front();
      end
      prev_pop = (fifo_if.fifo_pop === 1'b1);
      fifo_if.fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic push(input logic [DB-1:0] b);
      fifo_q.push_back(b);
      fifo_if.fifo_empty = 1'b0;
   endtask

   // Bit k of the frame on the line for byte b.
   function automatic logic exp_bit(input logic [DB-1:0] b, input int k);
      int ones;
      ones = 0;
      if (k == 0) return 1'b0;
      if (k <= DB) return b[k-1];
      if (PB == 1 && k == DB + 1) begin
         for (int i = 0; i < DB; i++) ones += int'(b[i]);
         return logic'(ones % 2);
      end
      return 1'b1;
   endfunction

   task automatic wait_pop(input string tag, input int budget, output int waited);
      waited = 0;
      do begin
         step();
         waited++;
      end while (fifo_if.fifo_pop !== 1'b1 && waited < budget);
      check({tag, "_pop_seen"}, 32'(fifo_if.fifo_pop), 1);
      exp_pops++;
   endtask

   // Called right after the POP cycle was sampled; ends on the first IDLE sample.
   task automatic frame(input logic [DB-1:0] b, input string tag, input int drop_cell);
      int bad_tx;
      int bad_busy;
      int bad_pop;
      bad_tx = 0;
      bad_busy = 0;
      bad_pop = 0;
      step();
      check({tag, "_wait_tx"}, 32'(tx), 1);
      check({tag, "_wait_busy"}, 32'(busy), 1);
      for (int k = 0; k < NBITS; k++) begin
         if (k == drop_cell) tx_enable = 1'b0;
         for (int c = 0; c < CPB; c++) begin
            step();
            if (tx !== exp_bit(b, k)) bad_tx++;
            if (busy !== 1'b1) bad_busy++;
            if (fifo_if.fifo_pop !== 1'b0) bad_pop++;
         end
      end
      check({tag, "_bad_tx_cycles"}, 32'(bad_tx), 0);
      check({tag, "_bad_busy_cycles"}, 32'(bad_busy), 0);
      check({tag, "_pops_in_frame"}, 32'(bad_pop), 0);
      step();
      check({tag, "_idle_tx"}, 32'(tx), 1);
      check({tag, "_idle_busy"}, 32'(busy), 0);
   endtask

   task automatic quiet(input string tag, input int cycles);
      int pops0;
      int bad;
      pops0 = pop_cnt;
      bad = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check({tag, "_no_pop"}, 32'(pop_cnt - pops0), 0);
      check({tag, "_line_idle"}, 32'(bad), 0);
   endtask

   initial begin
      int w;
      logic [DB-1:0] b1;
      logic [DB-1:0] b2;
      logic [DB-1:0] b3;
      logic [DB-1:0] rb;

      resetn = 1'b0;
      tx_enable = 1'b0;
      fifo_if.fifo_empty = 1'b1;
      fifo_if.fifo_data = '0;
      repeat (3) step();
      check("rst_tx", 32'(tx), 1);
      check("rst_pop", 32'(fifo_if.fifo_pop), 0);
      check("rst_busy", 32'(busy), 0);
      resetn = 1'b1;
      quiet("empty", 20);

      tx_enable = 1'b1;
      push(8'hA5);
      wait_pop("a5", 50, w);
      check("a5_pop_latency", 32'(w), 1);
      frame(8'hA5, "a5", -1);
      check("a5_pop_count", 32'(pop_cnt), 1);

      push(8'h07);
      wait_pop("x07", 50, w);
      frame(8'h07, "x07", -1);

      push(8'h00);
      push(8'hFF);
      wait_pop("b2b0", 50, w);
      frame(8'h00, "b2b0", -1);
      wait_pop("b2b1", 50, w);
      check("b2b_gap", 32'(w), 1);
      frame(8'hFF, "b2b1", -1);
      check("b2b_pop_count", 32'(pop_cnt), 4);

      tx_enable = 1'b0;
      b1 = DB'($urandom);
      b2 = DB'($urandom);
      push(b1);
      push(b2);
      quiet("dis", 20);
      tx_enable = 1'b1;
      wait_pop("en", 50, w);
      check("en_pop_latency", 32'(w), 1);
      frame(b1, "en", 3);
      quiet("dropped", 20);

      tx_enable = 1'b1;
      wait_pop("rst", 50, w);
      step();
      repeat (CPB * 4 + 2) step();
      check("rst_bit3", 32'(tx), 32'(b2[3]));
      resetn = 1'b0;
      #1;
      check("rst_async_tx", 32'(tx), 1);
      check("rst_async_busy", 32'(busy), 0);
      check("rst_async_pop", 32'(fifo_if.fifo_pop), 0);
      repeat (2) step();
      b3 = DB'($urandom);
      push(b3);
      resetn = 1'b1;
      wait_pop("after_rst", 50, w);
      check("after_rst_pop_latency", 32'(w), 1);
      frame(b3, "after_rst", -1);

      for (int n = 0; n < N_RAND; n++) begin
         rb = DB'($urandom);
         tx_enable = 1'b0;
         push(rb);
         repeat ($urandom_range(0, 5)) step();
         tx_enable = 1'b1;
         wait_pop("rand", 50, w);
         check("rand_pop_latency", 32'(w), 1);
         frame(rb, "rand", -1);
      end

      check("total_pops", 32'(pop_cnt), 32'(exp_pops));
      check("consecutive_pops", 32'(pop_consec), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
